mon_tx_arbiter: RTL

Schedules the outgoing monitor-bus frame slot between the three upstream frame sources: power-on reply, keyboard scancode and mouse report. It sits between the keyboard/power-on logic and the 40-bit frame sender, running in the `mon_clk` domain. It buffers one pending item per source, picks a winner, formats the 40-bit frame, and holds it until the sender accepts. It enforces an inter-frame gap and backs off while the sender is in audio-sample-request mode.

---
 rtl/mon_tx_pkg.sv | 30 +++
 rtl/mon_tx_gap_timer.sv | 34 +++
 rtl/mon_tx_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mon_tx_pkg.sv
// Shared constants and types for the monitor-bus transmit arbiter.
//   Opcodes for each frame source, grant_src encoding, FSM state type and
//   a helper that builds the 40-bit frame.
package mon_tx_pkg;

  localparam int unsigned FRAME_W   = 40;
  localparam int unsigned PAYLOAD_W = 16;

  localparam logic [7:0] OP_PWR_ON   = 8'h80;
  localparam logic [7:0] OP_KEYBOARD = 8'h41;
  localparam logic [7:0] OP_MOUSE    = 8'h42;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_PWR  = 2'd1;
  localparam logic [1:0] SRC_KB   = 2'd2;
  localparam logic [1:0] SRC_MS   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Frame layout: opcode, payload, then 16 zero bits.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] op,
                                                    input logic [PAYLOAD_W-1:0] payload);
    return {op, payload, 16'h0000};
  endfunction

endpackage

// File: rtl/mon_tx_gap_timer.sv
// Loadable down-counter used to time the inter-frame gap.
//   clk, reset : clock and asynchronous active-high reset
//   load       : load load_val (takes precedence over dec)
//   load_val   : gap length in cycles
//   dec        : count down by one while non-zero
//   done       : combinational, high in the last gap cycle (count <= 1)
module mon_tx_gap_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Done one cycle early so the gap state lasts exactly load_val cycles.
  assign done = (count <= W'(1));

endmodule

// File: rtl/mon_tx_arbiter.sv
// Monitor-bus transmit arbiter: buffers one item per source (power-on
// reply, keyboard scancode, mouse report), picks a winner, formats the
// 40-bit frame and holds it until the sender accepts, then enforces an
// inter-frame gap. New grants are blocked while audio_mode is high.
//   mon_clk, reset        : clock, asynchronous active-high reset
//   pwr_pulse             : single-cycle power-on reply request
//   kb_valid/kb_ready/kb_data : keyboard handshake and scancode
//   ms_valid/ms_ready/ms_data : mouse handshake and report
//   audio_mode            : sender in sample-request mode
//   out_data/out_valid/out_ready : frame to the sender
//   grant_src             : 0 none, 1 power-on, 2 keyboard, 3 mouse
// Optional feature: define MON_TX_ROUND_ROBIN_EN for keyboard/mouse
// round-robin; otherwise keyboard has fixed priority over mouse.
module mon_tx_arbiter
  import mon_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned GAP_W      = 5
) (
  input  logic        mon_clk,
  input  logic        reset,
  input  logic        pwr_pulse,
  input  logic        kb_valid,
  output logic        kb_ready,
  input  logic [15:0] kb_data,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [15:0] ms_data,
  input  logic        audio_mode,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  grant_src
);

  localparam bit GAP_EN = (GAP_CYCLES != 0);

  state_t      state;
  logic        pwr_pend;
  logic        kb_full;
  logic        ms_full;
  logic [15:0] kb_buf;
  logic [15:0] ms_buf;
  logic [1:0]  sel_src;
  logic [39:0] sel_frame;
  logic        gap_load;
  logic        gap_dec;
  logic        gap_done;
`ifdef MON_TX_ROUND_ROBIN_EN
  logic        rr_ptr;   // 0: keyboard next, 1: mouse next
`endif

  // Ready depends only on holding-register state; no bypass.
  assign kb_ready = ~kb_full;
  assign ms_ready = ~ms_full;

  // Winner selection among pending sources.
  always_comb begin
    sel_src = SRC_NONE;
    if (pwr_pend) begin
      sel_src = SRC_PWR;
    end else if (kb_full && ms_full) begin
`ifdef MON_TX_ROUND_ROBIN_EN
      sel_src = rr_ptr ? SRC_MS : SRC_KB;
`else
      sel_src = SRC_KB;
`endif
    end else if (kb_full) begin
      sel_src = SRC_KB;
    end else if (ms_full) begin
      sel_src = SRC_MS;
    end
  end

  // Frame for the selected source.
  always_comb begin
    sel_frame = '0;
    case (sel_src)
      SRC_PWR: sel_frame = make_frame(OP_PWR_ON, 16'h0000);
      SRC_KB:  sel_frame = make_frame(OP_KEYBOARD, kb_buf);
      SRC_MS:  sel_frame = make_frame(OP_MOUSE, ms_buf);
      default: sel_frame = '0;
    endcase
  end

  assign gap_load = (state == ST_ISSUE) && out_valid && out_ready;
  assign gap_dec  = (state == ST_GAP);

  mon_tx_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk      (mon_clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_CYCLES)),
    .dec      (gap_dec),
    .done     (gap_done)
  );

  // Holding registers, FSM and registered frame outputs.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pwr_pend  <= 1'b0;
      kb_full   <= 1'b0;
      ms_full   <= 1'b0;
      kb_buf    <= '0;
      ms_buf    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      grant_src <= SRC_NONE;
`ifdef MON_TX_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      if (kb_valid && !kb_full) begin
        kb_full <= 1'b1;
        kb_buf  <= kb_data;
      end
      if (ms_valid && !ms_full) begin
        ms_full <= 1'b1;
        ms_buf  <= ms_data;
      end
      if (pwr_pulse) begin
        pwr_pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (!audio_mode && (sel_src != SRC_NONE)) begin
            out_data  <= sel_frame;
            grant_src <= sel_src;
            state     <= ST_ISSUE;
            case (sel_src)
              // A pulse in the granting cycle stays pending for a later frame.
              SRC_PWR: pwr_pend <= pwr_pulse;
              SRC_KB: begin
                kb_full <= 1'b0;
`ifdef MON_TX_ROUND_ROBIN_EN
                rr_ptr  <= 1'b1;
`endif
              end
              SRC_MS: begin
                ms_full <= 1'b0;
`ifdef MON_TX_ROUND_ROBIN_EN
                rr_ptr  <= 1'b0;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          // Valid rises one cycle after the grant; held until accepted.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            grant_src <= SRC_NONE;
            state     <= GAP_EN ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
